axi_ram_slave: RTL

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_pkg.sv | 29 ++
 rtl/axi_ram_mem.sv | 38 +++
 rtl/axi_ram_slave.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI RAM slave: FSM states, response codes and burst types.
package axi_ram_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wstate_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // WRAP advances like INCR (no wrap boundary); FIXED and the reserved code hold.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      if (burst == BURST_INCR || burst == BURST_WRAP)
         return addr + (32'd1 << size);
      return addr;
   endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Word-organised RAM: one byte-enabled write port, one registered read port.
module axi_ram_mem
   import axi_ram_pkg::*;
#(
   parameter int unsigned AW = 12
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [3:0]    wstrb_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [3:0][7:0] mem_q [2**AW];
   logic [31:0]     rdata_q;

   // Contents are never reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][b] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Non-blocking read of mem_q yields old data on a same-cycle write.
   always_ff @(posedge clk_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave in front of a single-ported-per-direction RAM; independent read and
// write FSMs, one outstanding transaction each, OKAY responses only.
module axi_ram_slave
   import axi_ram_pkg::*;
#(
   parameter int unsigned MEM_AW = 12
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   wstate_e     wstate_q;
   logic [3:0]  awid_q, bid_q;
   logic [31:0] waddr_q, wnext_d;
   logic [7:0]  wlen_q, wcnt_q;
   logic [2:0]  wsize_q;
   logic [1:0]  wburst_q;
   logic        awready_q, wready_q, bvalid_q;

   rstate_e     rstate_q;
   logic [3:0]  rid_q;
   logic [31:0] raddr_q, rnext_d;
   logic [7:0]  rlen_q, rcnt_q;
   logic [2:0]  rsize_q;
   logic [1:0]  rburst_q;
   logic        arready_q, rvalid_q, rlast_q;

   logic        ar_fire, r_fire, w_fire, mem_re;
   logic [MEM_AW-1:0] mem_raddr;
   logic        unused_inputs;

   assign unused_inputs = ^{wid, wlast, arlock, arcache, arprot, awlock, awcache, awprot};

   assign wnext_d = next_addr(waddr_q, wsize_q, wburst_q);
   assign rnext_d = next_addr(raddr_q, rsize_q, rburst_q);

   assign ar_fire = arready_q & arvalid;
   assign r_fire  = rvalid_q & rready;
   // A beat presented during reset is dropped so an aborted burst leaves that word untouched.
   assign w_fire  = wready_q & wvalid & ~areset;

   // Prefetch the next word on every non-final R handshake for zero-bubble beats.
   assign mem_re    = ar_fire | (r_fire & ~rlast_q);
   assign mem_raddr = ar_fire ? araddr[MEM_AW+1:2] : rnext_d[MEM_AW+1:2];

   axi_ram_mem #(
      .AW (MEM_AW)
   ) u_mem (
      .clk_i   (aclk),
      .rst_i   (areset),
      .we_i    (w_fire),
      .waddr_i (waddr_q[MEM_AW+1:2]),
      .wstrb_i (wstrb),
      .wdata_i (wdata),
      .re_i    (mem_re),
      .raddr_i (mem_raddr),
      .rdata_o (rdata)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         awid_q    <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (awvalid) begin
                  awid_q    <= awid;
                  waddr_q   <= awaddr;
                  wlen_q    <= awlen;
                  wsize_q   <= awsize;
                  wburst_q  <= awburst;
                  wcnt_q    <= '0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wstate_q  <= W_DATA;
               end
            end
            W_DATA: begin
               if (wvalid) begin
                  waddr_q <= wnext_d;
                  wcnt_q  <= wcnt_q + 8'd1;
                  if (wcnt_q == wlen_q) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= awid_q;
                     wstate_q <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
            default: begin
               awready_q <= 1'b1;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
               wstate_q  <= W_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_fire) begin
                  rid_q     <= arid;
                  raddr_q   <= araddr;
                  rlen_q    <= arlen;
                  rsize_q   <= arsize;
                  rburst_q  <= arburst;
                  rcnt_q    <= '0;
                  rlast_q   <= (arlen == 8'd0);
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rstate_q  <= R_DATA;
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     rstate_q  <= R_IDLE;
                  end else begin
                     raddr_q <= rnext_d;
                     rcnt_q  <= rcnt_q + 8'd1;
                     rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                  end
               end
            end
            default: begin
               arready_q <= 1'b1;
               rvalid_q  <= 1'b0;
               rlast_q   <= 1'b0;
               rstate_q  <= R_IDLE;
            end
         endcase
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bid     = bid_q;
   assign bresp   = RESP_OKAY;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rid     = rid_q;
   assign rresp   = RESP_OKAY;

endmodule
